// File: rtl/dsc_pkg.sv
// Shared defaults for the d_storage_cells latch/flop reference pair.
// Imported by the RTL and by the testbench so both agree on width and reset value.
`timescale 1ns/1ps
package dsc_pkg;

  localparam int DSC_WIDTH   = 1;
  localparam int DSC_RST_VAL = 0;

endpackage : dsc_pkg

// File: rtl/d_storage_cells_if.sv
// Data/enable/output bundle for d_storage_cells.
// master: the side that drives D and en and observes both outputs.
// slave : the storage block itself.
`timescale 1ns/1ps
interface d_storage_cells_if
  import dsc_pkg::*;
#(
  parameter int WIDTH = DSC_WIDTH
) ();

  logic [WIDTH-1:0] D;
  logic             en;
  logic [WIDTH-1:0] Q_latch;
  logic [WIDTH-1:0] Q_ff;

  modport master (
    output D,
    output en,
    input  Q_latch,
    input  Q_ff
  );

  modport slave (
    input  D,
    input  en,
    output Q_latch,
    output Q_ff
  );

endinterface : d_storage_cells_if

// File: rtl/dsc_latch.sv
// WIDTH-wide level-sensitive transparent D latch.
// Optional asynchronous active-low reset when DSC_LATCH_RESET_EN is defined;
// without it the latch has no reset term and powers up unknown.
`timescale 1ns/1ps
module dsc_latch
  import dsc_pkg::*;
#(
  parameter int               WIDTH   = DSC_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DSC_RST_VAL)
) (
`ifdef DSC_LATCH_RESET_EN
  input  logic             reset,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef DSC_LATCH_RESET_EN
  // Reset overrides enable; otherwise transparent while en is high.
  // NOTE: this storage element is a latch by design; always_latch states that
  // intent so tools treat it as deliberate rather than an incomplete always_comb.
  always_latch begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end
`else
  // Transparent while en is high, holds the last passed value while low.
  always_latch begin
    if (en) begin
      q <= d;
    end
  end
`endif

endmodule : dsc_latch

// File: rtl/d_storage_cells.sv
// Golden latch/flop pair: a transparent D latch (dsc_latch) and an inline
// positive-edge D flop with asynchronous active-low reset, both fed from D.
// Optional macro DSC_LATCH_RESET_EN adds the reset term to the latch.
`timescale 1ns/1ps
module d_storage_cells
  import dsc_pkg::*;
#(
  parameter int               WIDTH   = DSC_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DSC_RST_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  d_storage_cells_if.slave  bus
);

  dsc_latch #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_latch (
`ifdef DSC_LATCH_RESET_EN
    .reset (reset),
`endif
    .en    (bus.en),
    .d     (bus.D),
    .q     (bus.Q_latch)
  );

  // Flop: asynchronous reset to RST_VAL, captures D on every rising clk edge.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs before any of them update in the same time step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.Q_ff <= RST_VAL;
    end else begin
      bus.Q_ff <= bus.D;
    end
  end

endmodule : d_storage_cells

// File: tb/tb_d_storage_cells.sv
// Directed self-checking bench for d_storage_cells on a 10 ns clock
// (posedges at 5, 15, 25, ... ns). Outputs are sampled 1 ns after each stimulus
// change or clock edge. Latch reset checks adapt to DSC_LATCH_RESET_EN.
`timescale 1ns/1ps
module tb_d_storage_cells;
  import dsc_pkg::*;

  localparam int               W  = DSC_WIDTH;
  localparam logic [W-1:0]     RV = W'(DSC_RST_VAL);

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  d_storage_cells_if #(.WIDTH(W)) bus ();

  d_storage_cells #(
    .WIDTH   (W),
    .RST_VAL (RV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input int t);
    if ($time < t) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    // Reset asserted from time zero, no clock edge yet.
    reset  = 1'b0;
    bus.D  = '0;
    bus.en = 1'b0;
    at(1);
    check("ff_reset_before_edge", bus.Q_ff, RV);
`ifdef DSC_LATCH_RESET_EN
    check("latch_reset_initial", bus.Q_latch, RV);
`endif
    at(16);
    check("ff_held_in_reset", bus.Q_ff, RV);

    // Release reset away from an edge; first capture of D=0 at 35 ns.
    at(30);
    reset = 1'b1;
    at(36);
    check("ff_capture_zero", bus.Q_ff, 1'b0);

    // Latch transparency and flop one-edge latency.
    at(40);
    bus.D  = 1'b1;
    bus.en = 1'b1;
    at(41);
    check("latch_transparent_1", bus.Q_latch, 1'b1);
    check("ff_not_before_edge", bus.Q_ff, 1'b0);
    at(46);
    check("ff_capture_one", bus.Q_ff, 1'b1);

    // Latch closes, then D drops: latch must hold 1.
    at(50);
    bus.en = 1'b0;
    at(51);
    bus.D = 1'b0;
    at(52);
    check("latch_hold_after_close", bus.Q_latch, 1'b1);
    at(53);
    bus.D = 1'b1;

    // D pulses 0->1->0 between edges must not disturb the flop.
    at(57);
    bus.D = 1'b0;
    at(59);
    bus.D = 1'b1;
    at(61);
    bus.D = 1'b0;
    at(63);
    check("ff_ignores_mid_pulse", bus.Q_ff, 1'b1);
    check("latch_ignores_d_closed", bus.Q_latch, 1'b1);
    at(64);
    bus.D = 1'b1;
    at(76);
    check("ff_steady_one", bus.Q_ff, 1'b1);

    // Asynchronous reset mid-cycle.
    at(82);
    reset = 1'b0;
    at(83);
    check("ff_async_reset", bus.Q_ff, RV);
`ifdef DSC_LATCH_RESET_EN
    check("latch_reset_closed", bus.Q_latch, RV);
`else
    check("latch_no_reset_term", bus.Q_latch, 1'b1);
`endif
    at(86);
    check("ff_reset_hold_85", bus.Q_ff, RV);
    at(96);
    check("ff_reset_hold_95", bus.Q_ff, RV);

    // Release at 100 ns with D=1: capture at 105, not earlier.
    at(100);
    reset = 1'b1;
    bus.D = 1'b1;
    at(101);
    check("ff_no_capture_on_release", bus.Q_ff, RV);
    at(106);
    check("ff_first_capture_after_release", bus.Q_ff, 1'b1);

    // Reopen latch with D=0.
    at(110);
    bus.en = 1'b1;
    bus.D  = 1'b0;
    at(111);
    check("latch_transparent_0", bus.Q_latch, 1'b0);
    at(116);
    check("ff_capture_zero_again", bus.Q_ff, 1'b0);

    // Reset with latch open and D=1.
    at(120);
    bus.D = 1'b1;
    reset = 1'b0;
    at(121);
`ifdef DSC_LATCH_RESET_EN
    check("latch_reset_overrides_en", bus.Q_latch, RV);
`else
    check("latch_open_during_reset", bus.Q_latch, 1'b1);
`endif
    at(126);
    check("ff_reset_second", bus.Q_ff, RV);

    // Reset release with en=1: latch immediately transparent again.
    at(130);
    reset = 1'b1;
    at(131);
    check("latch_resume_after_reset", bus.Q_latch, 1'b1);
    at(136);
    check("ff_capture_after_second_release", bus.Q_ff, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_d_storage_cells
